bus_request_unit: RTL and testbench

BUS_REQUEST_UNIT -- requirements
Module: bus_request_unit

---
 rtl/bus_request_unit_pkg.sv | 23 ++
 rtl/bus_request_unit_timeout.sv | 33 +++
 rtl/bus_request_unit.sv | 151 +++++++++++++++
 tb/tb_bus_request_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_request_unit_pkg.sv
// Shared types and constants for the bus request unit.
// The watchdog is present only when BUS_REQUEST_TIMEOUT_EN is defined.
package bus_request_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DATA_RD = 2'd2,
    ST_DATA_WR = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    BUS_CMD_NONE  = 2'b00,
    BUS_CMD_READ  = 2'b01,
    BUS_CMD_WRITE = 2'b10
  } bus_cmd_t;

  // Returned to the core when an instruction fetch is aborted (addi x0,x0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int TIMER_W = 8;

endpackage

// File: rtl/bus_request_unit_timeout.sv
// bus_timeout_counter: counts wait cycles and flags the cycle on which the
// LIMIT-th wait cycle ends. Instantiated only when BUS_REQUEST_TIMEOUT_EN is defined.
module bus_timeout_counter
  import bus_request_unit_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // The count holds the number of completed wait cycles, so the edge that
  // closes wait cycle LIMIT sees LAST.
  assign expired = enable && !clear && (r_count == LAST);

endmodule

// File: rtl/bus_request_unit.sv
// Bus request unit: arbitrates core fetch/load/store requests onto one memory bus.
// Optional watchdog abort enabled by defining BUS_REQUEST_TIMEOUT_EN.
module bus_request_unit
  import bus_request_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] pc,
  input  logic        data_read_req,
  input  logic        data_write_req,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [31:0] data_in_BUS,
  input  logic        bus_full,
  output logic [31:0] address_out,
  output logic [31:0] data_out_BUS,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        instr_wait,
  output logic        bus_err
);

  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("bus_request_unit: TIMEOUT_CYCLES must be in 2..255");
  end

  state_t      r_state;
  bus_cmd_t    r_bus_cmd;
  logic [31:0] r_address;
  logic [31:0] r_wdata;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic [31:0] r_rdata;
  logic        r_rdata_valid;

`ifdef BUS_REQUEST_TIMEOUT_EN
  logic w_expired;
  logic w_clear;
  logic w_waiting;
  logic r_bus_err;

  // Held clear throughout IDLE, so every wait state starts counting from zero.
  assign w_clear   = (r_state == ST_IDLE);
  assign w_waiting = (r_state != ST_IDLE);

  bus_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_clear),
    .enable  (w_waiting),
    .expired (w_expired)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_bus_cmd     <= BUS_CMD_NONE;
      r_address     <= '0;
      r_wdata       <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
`ifdef BUS_REQUEST_TIMEOUT_EN
      r_bus_err     <= 1'b0;
`endif
    end else begin
      r_instr_valid <= 1'b0;
      r_rdata_valid <= 1'b0;
`ifdef BUS_REQUEST_TIMEOUT_EN
      r_bus_err     <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (data_write_req) begin
            r_state   <= ST_DATA_WR;
            r_bus_cmd <= BUS_CMD_WRITE;
            r_address <= data_addr;
            r_wdata   <= data_wdata;
          end else if (data_read_req) begin
            r_state   <= ST_DATA_RD;
            r_bus_cmd <= BUS_CMD_READ;
            r_address <= data_addr;
          end else if (fetch_req) begin
            r_state   <= ST_FETCH;
            r_bus_cmd <= BUS_CMD_READ;
            r_address <= pc;
          end
        end
        ST_FETCH, ST_DATA_RD, ST_DATA_WR: begin
          // A completion on the expiry edge wins over the watchdog.
          if (bus_full) begin
            r_state   <= ST_IDLE;
            r_bus_cmd <= BUS_CMD_NONE;
            if (r_state == ST_FETCH) begin
              r_instr       <= data_in_BUS;
              r_instr_valid <= 1'b1;
            end else begin
              if (r_state == ST_DATA_RD) begin
                r_rdata <= data_in_BUS;
              end
              r_rdata_valid <= 1'b1;
            end
          end
`ifdef BUS_REQUEST_TIMEOUT_EN
          else if (w_expired) begin
            r_state   <= ST_IDLE;
            r_bus_cmd <= BUS_CMD_NONE;
            r_bus_err <= 1'b1;
            if (r_state == ST_FETCH) begin
              r_instr       <= NOP_INSTR;
              r_instr_valid <= 1'b1;
            end else begin
              r_rdata       <= '0;
              r_rdata_valid <= 1'b1;
            end
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign address_out  = r_address;
  assign data_out_BUS = r_wdata;
  assign bus_read     = (r_bus_cmd == BUS_CMD_READ);
  assign bus_write    = (r_bus_cmd == BUS_CMD_WRITE);
  assign instr_out    = r_instr;
  assign instr_valid  = r_instr_valid;
  assign rdata_out    = r_rdata;
  assign rdata_valid  = r_rdata_valid;
  assign instr_wait   = (r_state != ST_IDLE);

`ifdef BUS_REQUEST_TIMEOUT_EN
  assign bus_err = r_bus_err;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_request_unit.sv
// Directed self-checking bench for bus_request_unit; the timeout scenario
// follows BUS_REQUEST_TIMEOUT_EN.
module tb_bus_request_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] pc;
  logic        data_read_req;
  logic        data_write_req;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_in_BUS;
  logic        bus_full;
  logic [31:0] address_out;
  logic [31:0] data_out_BUS;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        instr_wait;
  logic        bus_err;

  int tests_run = 0;
  int tests_failed = 0;

  bus_request_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req      (fetch_req),
    .pc             (pc),
    .data_read_req  (data_read_req),
    .data_write_req (data_write_req),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_in_BUS    (data_in_BUS),
    .bus_full       (bus_full),
    .address_out    (address_out),
    .data_out_BUS   (data_out_BUS),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid),
    .rdata_out      (rdata_out),
    .rdata_valid    (rdata_valid),
    .instr_wait     (instr_wait),
    .bus_err        (bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},   address_out,  32'h0);
    chk({tag, "_wdata"},  data_out_BUS, 32'h0);
    chk({tag, "_rd"},     {31'h0, bus_read},    32'h0);
    chk({tag, "_wr"},     {31'h0, bus_write},   32'h0);
    chk({tag, "_instr"},  instr_out,    32'h0);
    chk({tag, "_ivld"},   {31'h0, instr_valid}, 32'h0);
    chk({tag, "_rdata"},  rdata_out,    32'h0);
    chk({tag, "_rvld"},   {31'h0, rdata_valid}, 32'h0);
    chk({tag, "_wait"},   {31'h0, instr_wait},  32'h0);
    chk({tag, "_err"},    {31'h0, bus_err},     32'h0);
  endtask

  initial begin
    rst = 1'b1;
    fetch_req = 1'b0; pc = '0;
    data_read_req = 1'b0; data_write_req = 1'b0;
    data_addr = '0; data_wdata = '0;
    data_in_BUS = '0; bus_full = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk("idle_wait", {31'h0, instr_wait}, 32'h0);

    // Fetch from 0x4, bus completes on the second wait edge
    fetch_req = 1'b1; pc = 32'h0000_0004;
    tick();
    fetch_req = 1'b0;
    chk("fetch_wait", {31'h0, instr_wait}, 32'h1);
    chk("fetch_rd",   {31'h0, bus_read},   32'h1);
    chk("fetch_addr", address_out, 32'h0000_0004);
    tick();
    chk("fetch_addr_hold", address_out, 32'h0000_0004);
    chk("fetch_no_vld", {31'h0, instr_valid}, 32'h0);
    bus_full = 1'b1; data_in_BUS = 32'h0020_81B3;
    tick();
    bus_full = 1'b0;
    chk("fetch_instr", instr_out, 32'h0020_81B3);
    chk("fetch_vld",   {31'h0, instr_valid}, 32'h1);
    chk("fetch_done_wait", {31'h0, instr_wait}, 32'h0);
    chk("fetch_done_rd",   {31'h0, bus_read},   32'h0);
    $display("[TB] fetch pc=00000004 instr_out=%h", instr_out);
    tick();
    chk("fetch_vld_pulse", {31'h0, instr_valid}, 32'h0);
    chk("fetch_instr_hold", instr_out, 32'h0020_81B3);

    // bus_full in IDLE is ignored
    bus_full = 1'b1; data_in_BUS = 32'hDEAD_BEEF;
    tick();
    bus_full = 1'b0;
    chk("idle_bf_ivld", {31'h0, instr_valid}, 32'h0);
    chk("idle_bf_rvld", {31'h0, rdata_valid}, 32'h0);
    chk("idle_bf_instr", instr_out, 32'h0020_81B3);

    // Load from 0x7
    data_read_req = 1'b1; data_addr = 32'h0000_0007;
    tick();
    data_read_req = 1'b0;
    chk("load_rd",   {31'h0, bus_read}, 32'h1);
    chk("load_addr", address_out, 32'h0000_0007);
    bus_full = 1'b1; data_in_BUS = 32'h0000_FFFF;
    tick();
    bus_full = 1'b0;
    chk("load_rdata", rdata_out, 32'h0000_FFFF);
    chk("load_vld",   {31'h0, rdata_valid}, 32'h1);
    chk("load_instr_hold", instr_out, 32'h0020_81B3);
    $display("[TB] load addr=00000007 rdata_out=%h", rdata_out);

    // Store to 0x20; requests changing mid-flight must not disturb it
    data_write_req = 1'b1; data_addr = 32'h0000_0020; data_wdata = 32'hFFFF_FFFF;
    tick();
    data_write_req = 1'b0;
    chk("store_wr",    {31'h0, bus_write}, 32'h1);
    chk("store_rd",    {31'h0, bus_read},  32'h0);
    chk("store_wdata", data_out_BUS, 32'hFFFF_FFFF);
    chk("store_addr",  address_out,  32'h0000_0020);
    fetch_req = 1'b1; data_addr = 32'h0000_0999; data_wdata = 32'h1111_1111;
    tick();
    fetch_req = 1'b0;
    chk("store_hold_wr",    {31'h0, bus_write}, 32'h1);
    chk("store_hold_addr",  address_out,  32'h0000_0020);
    chk("store_hold_wdata", data_out_BUS, 32'hFFFF_FFFF);
    bus_full = 1'b1; data_in_BUS = 32'h1234_5678;
    tick();
    bus_full = 1'b0;
    chk("store_vld",   {31'h0, rdata_valid}, 32'h1);
    chk("store_rdata", rdata_out, 32'h0000_FFFF);
    chk("store_done_wr", {31'h0, bus_write}, 32'h0);
    $display("[TB] store addr=00000020 rdata_valid=%0d", rdata_valid);
    tick();

    // Priority: write, then read, then fetch, with no idle gap between them
    fetch_req = 1'b1; data_read_req = 1'b1; data_write_req = 1'b1;
    pc = 32'h0000_0100; data_addr = 32'h0000_0200; data_wdata = 32'hAAAA_5555;
    tick();
    chk("prio1_wr",   {31'h0, bus_write}, 32'h1);
    chk("prio1_addr", address_out, 32'h0000_0200);
    data_write_req = 1'b0; bus_full = 1'b1; data_in_BUS = 32'h0BAD_0BAD;
    tick();
    bus_full = 1'b0;
    chk("prio1_vld",  {31'h0, rdata_valid}, 32'h1);
    chk("prio1_rdata", rdata_out, 32'h0000_FFFF);
    tick();
    chk("prio2_rd",   {31'h0, bus_read},   32'h1);
    chk("prio2_wait", {31'h0, instr_wait}, 32'h1);
    data_read_req = 1'b0; bus_full = 1'b1; data_in_BUS = 32'hCAFE_F00D;
    tick();
    bus_full = 1'b0;
    chk("prio2_rdata", rdata_out, 32'hCAFE_F00D);
    chk("prio2_vld",   {31'h0, rdata_valid}, 32'h1);
    tick();
    chk("prio3_rd",   {31'h0, bus_read}, 32'h1);
    chk("prio3_addr", address_out, 32'h0000_0100);
    fetch_req = 1'b0; bus_full = 1'b1; data_in_BUS = 32'h0050_0093;
    tick();
    bus_full = 1'b0;
    chk("prio3_instr", instr_out, 32'h0050_0093);
    chk("prio3_vld",   {31'h0, instr_valid}, 32'h1);
    $display("[TB] priority write/read/fetch instr_out=%h rdata_out=%h", instr_out, rdata_out);
    tick();

    // Asynchronous reset in the middle of a fetch
    fetch_req = 1'b1; pc = 32'h0000_0040;
    tick();
    fetch_req = 1'b0;
    chk("rstmid_wait", {31'h0, instr_wait}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_async");
    tick();
    rst = 1'b0;
    bus_full = 1'b1; data_in_BUS = 32'hDEAD_0001;
    tick();
    bus_full = 1'b0;
    chk_all_zero("rst_after");
    $display("[TB] reset mid-fetch instr_wait=%0d instr_out=%h", instr_wait, instr_out);

    // Fetch with no bus completion
    fetch_req = 1'b1; pc = 32'h0000_0080;
    tick();
    fetch_req = 1'b0;
`ifdef BUS_REQUEST_TIMEOUT_EN
    for (int i = 1; i < 16; i++) tick();
    chk("to_pre_err",  {31'h0, bus_err},    32'h0);
    chk("to_pre_wait", {31'h0, instr_wait}, 32'h1);
    tick();
    chk("to_err",   {31'h0, bus_err},     32'h1);
    chk("to_vld",   {31'h0, instr_valid}, 32'h1);
    chk("to_instr", instr_out, 32'h0000_0013);
    chk("to_wait",  {31'h0, instr_wait},  32'h0);
    tick();
    chk("to_err_pulse", {31'h0, bus_err}, 32'h0);
    $display("[TB] timeout fetch instr_out=%h", instr_out);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("nto_wait", {31'h0, instr_wait},  32'h1);
    chk("nto_err",  {31'h0, bus_err},     32'h0);
    chk("nto_vld",  {31'h0, instr_valid}, 32'h0);
    bus_full = 1'b1; data_in_BUS = 32'h0000_0033;
    tick();
    bus_full = 1'b0;
    chk("nto_instr", instr_out, 32'h0000_0033);
    $display("[TB] no-watchdog fetch held wait, instr_out=%h", instr_out);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
